// File: rtl/axi_console_pkg.sv
// Shared definitions for the AXI4-lite console: register map, STATUS layout,
// UART state encoding and the STATUS packing helpers.
package axi_console_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_PASS   = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam int ST_BIT_FULL  = 0;
    localparam int ST_BIT_EMPTY = 1;
    localparam int ST_BIT_BUSY  = 2;
    localparam int ST_BIT_OVF   = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    function automatic logic [7:0] sat_count8(input logic [8:0] count);
        if (count > 9'd255) begin
            return 8'hFF;
        end else begin
            return count[7:0];
        end
    endfunction

    function automatic logic [31:0] pack_status(input logic [7:0] count, input logic ovf,
                                                input logic busy, input logic empty,
                                                input logic full);
        logic [31:0] s;
        s = 32'd0;
        s[ST_COUNT_LSB +: 8] = count;
        s[ST_BIT_OVF]        = ovf;
        s[ST_BIT_BUSY]       = busy;
        s[ST_BIT_EMPTY]      = empty;
        s[ST_BIT_FULL]       = full;
        return s;
    endfunction

endpackage

// File: rtl/axi_console_fifo.sv
// Byte FIFO feeding the UART transmitter; power-of-two depth, show-ahead read.
module axi_console_fifo
    import axi_console_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [7:0]                 i_data,
    output logic [7:0]                 o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1'b1);
                2'b01:   r_count <= r_count - (AW+1)'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/axi_console.sv
// AXI4-lite test console: TXDATA bytes go through a FIFO to an 8N1 UART,
// STATUS reports FIFO/UART state, PASS sets a sticky tests_passed flag.
module axi_console
    import axi_console_pkg::*;
#(
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] PASS_MAGIC = 32'd123456789
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_axi_awvalid,
    output logic        mem_axi_awready,
    input  logic [31:0] mem_axi_awaddr,
    input  logic [2:0]  mem_axi_awprot,
    input  logic        mem_axi_wvalid,
    output logic        mem_axi_wready,
    input  logic [31:0] mem_axi_wdata,
    input  logic [3:0]  mem_axi_wstrb,
    output logic        mem_axi_bvalid,
    input  logic        mem_axi_bready,
    input  logic        mem_axi_arvalid,
    output logic        mem_axi_arready,
    input  logic [31:0] mem_axi_araddr,
    input  logic [2:0]  mem_axi_arprot,
    output logic        mem_axi_rvalid,
    input  logic        mem_axi_rready,
    output logic [31:0] mem_axi_rdata,
    output logic        uart_tx,
    output logic        tests_passed
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic        r_aw_held, r_w_held, r_bvalid;
    logic [1:0]  r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_overflow, r_tests_passed;
    uart_state_t r_state;
    logic [15:0] r_div_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_uart_tx;

    logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [1:0]  w_wr_off;
    logic [31:0] w_wr_data;
    logic [3:0]  w_wr_strb;
    logic        w_push_req, w_push, w_pass_hit, w_pop, w_tx_busy;
    logic [7:0]  w_fifo_data;
    logic        w_fifo_full, w_fifo_empty;
    logic [AW:0] w_fifo_count;
    logic [8:0]  w_count9;
    logic [31:0] w_status, w_rd_value;
    logic        w_unused;

    assign mem_axi_awready = !r_aw_held && !r_bvalid;
    assign mem_axi_wready  = !r_w_held && !r_bvalid;
    assign mem_axi_arready = !r_rvalid;
    assign mem_axi_bvalid  = r_bvalid;
    assign mem_axi_rvalid  = r_rvalid;
    assign mem_axi_rdata   = r_rdata;
    assign uart_tx         = r_uart_tx;
    assign tests_passed    = r_tests_passed;

    assign w_aw_hs   = mem_axi_awvalid && mem_axi_awready;
    assign w_w_hs    = mem_axi_wvalid && mem_axi_wready;
    assign w_ar_hs   = mem_axi_arvalid && mem_axi_arready;
    assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_wr_off  = r_aw_held ? r_awaddr : mem_axi_awaddr[3:2];
    assign w_wr_data = r_w_held ? r_wdata : mem_axi_wdata;
    assign w_wr_strb = r_w_held ? r_wstrb : mem_axi_wstrb;
    assign w_push    = w_push_req && !w_fifo_full;
    assign w_pop     = (r_state == UART_IDLE) && !w_fifo_empty;
    assign w_tx_busy = (r_state != UART_IDLE);
    assign w_status  = pack_status(sat_count8(w_count9), r_overflow, w_tx_busy,
                                   w_fifo_empty, w_fifo_full);
    assign w_unused  = ^{mem_axi_awprot, mem_axi_arprot, mem_axi_awaddr[31:4],
                         mem_axi_awaddr[1:0], mem_axi_araddr[31:4], mem_axi_araddr[1:0]};

    // Decode the committed write into FIFO push and PASS hit strobes.
    always_comb begin
        w_push_req = 1'b0;
        w_pass_hit = 1'b0;
        if (w_commit) begin
            case (w_wr_off)
                OFF_TXDATA: w_push_req = w_wr_strb[0];
                OFF_PASS:   w_pass_hit = (w_wr_data == PASS_MAGIC) && (w_wr_strb == 4'hF);
                OFF_STATUS, OFF_RSVD: begin
                    w_push_req = 1'b0;
                    w_pass_hit = 1'b0;
                end
                default: begin
                    w_push_req = 1'b0;
                    w_pass_hit = 1'b0;
                end
            endcase
        end else begin
            w_push_req = 1'b0;
            w_pass_hit = 1'b0;
        end
    end

    // Widen the FIFO count to a fixed 9 bits for STATUS saturation.
    always_comb begin
        w_count9        = 9'd0;
        w_count9[AW:0]  = w_fifo_count;
    end

    // Read-data mux for the accepted read address.
    always_comb begin
        case (mem_axi_araddr[3:2])
            OFF_STATUS: w_rd_value = w_status;
            default:    w_rd_value = 32'd0;
        endcase
    end

    // Write channel: address and data may arrive in either order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= 2'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_bvalid  <= 1'b0;
        end else if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= mem_axi_awaddr[3:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= mem_axi_wdata;
                r_wstrb  <= mem_axi_wstrb;
            end
            if (r_bvalid && mem_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read channel plus sticky flags; a new overflow beats a STATUS-read clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rvalid       <= 1'b0;
            r_rdata        <= 32'd0;
            r_overflow     <= 1'b0;
            r_tests_passed <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_value;
            end else if (r_rvalid && mem_axi_rready) begin
                r_rvalid <= 1'b0;
            end
            if (w_push_req && w_fifo_full) begin
                r_overflow <= 1'b1;
            end else if (w_ar_hs && (mem_axi_araddr[3:2] == OFF_STATUS)) begin
                r_overflow <= 1'b0;
            end
            if (w_pass_hit) begin
                r_tests_passed <= 1'b1;
            end
        end
    end

    // UART transmitter: line value is registered at each state/bit boundary.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= UART_IDLE;
            r_div_cnt <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_uart_tx <= 1'b1;
        end else begin
            case (r_state)
                UART_IDLE: begin
                    r_uart_tx <= 1'b1;
                    if (!w_fifo_empty) begin
                        r_shift   <= w_fifo_data;
                        r_div_cnt <= 16'd0;
                        r_uart_tx <= 1'b0;
                        r_state   <= UART_START;
                    end
                end
                UART_START: begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_div_cnt <= 16'd0;
                        r_bit_idx <= 3'd0;
                        r_uart_tx <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_state   <= UART_DATA;
                    end else begin
                        r_div_cnt <= r_div_cnt + 16'd1;
                    end
                end
                UART_DATA: begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_div_cnt <= 16'd0;
                        if (r_bit_idx == 3'd7) begin
                            r_uart_tx <= 1'b1;
                            r_state   <= UART_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_uart_tx <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 16'd1;
                    end
                end
                UART_STOP: begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_div_cnt <= 16'd0;
                        r_state   <= UART_IDLE;
                    end else begin
                        r_div_cnt <= r_div_cnt + 16'd1;
                    end
                end
                default: begin
                    r_uart_tx <= 1'b1;
                    r_state   <= UART_IDLE;
                end
            endcase
        end
    end

    axi_console_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_wr_data[7:0]),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_axi_console.sv
// Directed bench: instance 0 runs CLK_DIV=4, instance 1 runs CLK_DIV=16 for the overflow case.
module tb_axi_console;

    logic clk;
    logic resetn;
    logic [1:0]        awvalid, wvalid, bready, arvalid, rready;
    logic [1:0][31:0]  awaddr, wdata, araddr;
    logic [1:0][3:0]   wstrb;
    logic [1:0][2:0]   awprot, arprot;
    logic [1:0]        awready, wready, bvalid, arready, rvalid, uart_tx, tests_passed;
    logic [1:0][31:0]  rdata;

    int n_err = 0;
    int n_chk = 0;
    logic [31:0] rd;
    logic [9:0]  frame;

    axi_console #(.CLK_DIV(4), .FIFO_DEPTH(16), .PASS_MAGIC(32'd123456789)) u_dut0 (
        .clk(clk), .resetn(resetn),
        .mem_axi_awvalid(awvalid[0]), .mem_axi_awready(awready[0]),
        .mem_axi_awaddr(awaddr[0]), .mem_axi_awprot(awprot[0]),
        .mem_axi_wvalid(wvalid[0]), .mem_axi_wready(wready[0]),
        .mem_axi_wdata(wdata[0]), .mem_axi_wstrb(wstrb[0]),
        .mem_axi_bvalid(bvalid[0]), .mem_axi_bready(bready[0]),
        .mem_axi_arvalid(arvalid[0]), .mem_axi_arready(arready[0]),
        .mem_axi_araddr(araddr[0]), .mem_axi_arprot(arprot[0]),
        .mem_axi_rvalid(rvalid[0]), .mem_axi_rready(rready[0]),
        .mem_axi_rdata(rdata[0]), .uart_tx(uart_tx[0]), .tests_passed(tests_passed[0])
    );

    axi_console #(.CLK_DIV(16), .FIFO_DEPTH(16), .PASS_MAGIC(32'd123456789)) u_dut1 (
        .clk(clk), .resetn(resetn),
        .mem_axi_awvalid(awvalid[1]), .mem_axi_awready(awready[1]),
        .mem_axi_awaddr(awaddr[1]), .mem_axi_awprot(awprot[1]),
        .mem_axi_wvalid(wvalid[1]), .mem_axi_wready(wready[1]),
        .mem_axi_wdata(wdata[1]), .mem_axi_wstrb(wstrb[1]),
        .mem_axi_bvalid(bvalid[1]), .mem_axi_bready(bready[1]),
        .mem_axi_arvalid(arvalid[1]), .mem_axi_arready(arready[1]),
        .mem_axi_araddr(araddr[1]), .mem_axi_arprot(arprot[1]),
        .mem_axi_rvalid(rvalid[1]), .mem_axi_rready(rready[1]),
        .mem_axi_rdata(rdata[1]), .uart_tx(uart_tx[1]), .tests_passed(tests_passed[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; address and data presented together, bready high.
    task automatic axi_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        awaddr[d]  = addr;
        wdata[d]   = data;
        wstrb[d]   = strb;
        awvalid[d] = 1'b1;
        wvalid[d]  = 1'b1;
        @(negedge clk);
        awvalid[d] = 1'b0;
        wvalid[d]  = 1'b0;
        chk("wr_bvalid_set", {31'd0, bvalid[d]}, 32'd1);
        @(negedge clk);
        chk("wr_bvalid_clr", {31'd0, bvalid[d]}, 32'd0);
    endtask

    task automatic axi_read(input int d, input logic [31:0] addr, output logic [31:0] data);
        araddr[d]  = addr;
        arvalid[d] = 1'b1;
        @(negedge clk);
        arvalid[d] = 1'b0;
        chk("rd_rvalid_set", {31'd0, rvalid[d]}, 32'd1);
        data = rdata[d];
        @(negedge clk);
    endtask

    initial begin
        resetn  = 1'b0;
        awvalid = 2'b00; wvalid = 2'b00; arvalid = 2'b00;
        bready  = 2'b11; rready = 2'b11;
        awaddr  = '0; wdata = '0; araddr = '0; wstrb = '0;
        awprot  = '0; arprot = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_uart_tx",  {30'd0, uart_tx}, 32'd3);
        chk("rst_bvalid",   {30'd0, bvalid}, 32'd0);
        chk("rst_rvalid",   {30'd0, rvalid}, 32'd0);
        chk("rst_rdata",    rdata[0], 32'd0);
        chk("rst_passed",   {30'd0, tests_passed}, 32'd0);
        chk("rst_readies",  {29'd0, awready[0], wready[0], arready[0]}, 32'd7);
        resetn = 1'b1;
        @(negedge clk);

        // PASS register: partial strobe, reserved offset, magic, then non-magic
        axi_write(0, 32'h0000_0008, 32'd123456789, 4'h7);
        chk("pass_strb7", {31'd0, tests_passed[0]}, 32'd0);
        axi_write(0, 32'h0000_000C, 32'd123456789, 4'hF);
        chk("pass_rsvd", {31'd0, tests_passed[0]}, 32'd0);
        axi_write(0, 32'h0000_0008, 32'd123456789, 4'hF);
        chk("pass_set", {31'd0, tests_passed[0]}, 32'd1);
        axi_write(0, 32'h0000_0008, 32'd0, 4'hF);
        chk("pass_sticky", {31'd0, tests_passed[0]}, 32'd1);

        // TXDATA with wstrb[0]=0 pushes nothing
        axi_write(0, 32'h0000_0000, 32'h0000_0041, 4'hE);
        @(negedge clk);
        axi_read(0, 32'h0000_0004, rd);
        chk("strb0_noop_status", rd, 32'h0000_0002);

        // Reserved read then STATUS with rready held low
        rready[0]  = 1'b0;
        araddr[0]  = 32'h0000_000C;
        arvalid[0] = 1'b1;
        @(negedge clk);
        chk("rsv_rvalid", {31'd0, rvalid[0]}, 32'd1);
        chk("rsv_rdata", rdata[0], 32'd0);
        chk("rsv_arready", {31'd0, arready[0]}, 32'd0);
        araddr[0] = 32'h0000_0004;
        @(negedge clk);
        chk("rsv_hold_rvalid", {31'd0, rvalid[0]}, 32'd1);
        chk("rsv_hold_arready", {31'd0, arready[0]}, 32'd0);
        chk("rsv_hold_rdata", rdata[0], 32'd0);
        @(negedge clk);
        chk("rsv_hold2_rvalid", {31'd0, rvalid[0]}, 32'd1);
        rready[0] = 1'b1;
        @(negedge clk);
        chk("rsv_drop_rvalid", {31'd0, rvalid[0]}, 32'd0);
        chk("rsv_drop_arready", {31'd0, arready[0]}, 32'd1);
        @(negedge clk);
        arvalid[0] = 1'b0;
        chk("st_after_rvalid", {31'd0, rvalid[0]}, 32'd1);
        chk("st_after_rdata", rdata[0], 32'h0000_0002);
        @(negedge clk);

        // UART frame for 0x41 at 4 clocks per bit; upper address bits ignored
        axi_write(0, 32'h0000_1000, 32'h0000_0041, 4'hF);
        frame = {1'b1, 8'h41, 1'b0};
        for (int k = 0; k < 40; k++) begin
            chk("tx_bit", {31'd0, uart_tx[0]}, {31'd0, frame[k / 4]});
            @(negedge clk);
        end
        chk("tx_idle_after", {31'd0, uart_tx[0]}, 32'd1);
        axi_read(0, 32'h0000_0004, rd);
        chk("tx_done_status", rd, 32'h0000_0002);

        // Data 3 cycles ahead of address, then bready low for 5 cycles
        bready[0] = 1'b0;
        awaddr[0] = 32'h0000_0000;
        wdata[0]  = 32'h0000_005A;
        wstrb[0]  = 4'hF;
        wvalid[0] = 1'b1;
        @(negedge clk);
        chk("wfirst_wready", {31'd0, wready[0]}, 32'd0);
        chk("wfirst_awready", {31'd0, awready[0]}, 32'd1);
        chk("wfirst_bvalid", {31'd0, bvalid[0]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        awvalid[0] = 1'b1;
        @(negedge clk);
        awvalid[0] = 1'b0;
        wvalid[0]  = 1'b0;
        chk("wfirst_awready_b", {31'd0, awready[0]}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("bvalid_hold", {31'd0, bvalid[0]}, 32'd1);
            @(negedge clk);
        end
        bready[0] = 1'b1;
        @(negedge clk);
        chk("bvalid_release", {31'd0, bvalid[0]}, 32'd0);
        axi_read(0, 32'h0000_0004, rd);
        chk("single_push_busy", rd, 32'h0000_0006);
        repeat (40) @(negedge clk);
        axi_read(0, 32'h0000_0004, rd);
        chk("single_push_idle", rd, 32'h0000_0002);

        // Overflow on the CLK_DIV=16 instance: 20 back-to-back bytes
        for (int i = 0; i < 20; i++) begin
            axi_write(1, 32'h0000_0000, 32'(i + 1), 4'hF);
        end
        axi_read(1, 32'h0000_0004, rd);
        chk("ovf_status", rd, 32'h0000_100D);
        axi_read(1, 32'h0000_0004, rd);
        chk("ovf_cleared", rd, 32'h0000_1005);

        // Reset in the middle of a data bit
        axi_write(0, 32'h0000_0000, 32'h0000_00A5, 4'hF);
        repeat (10) @(negedge clk);
        chk("mid_frame_bit1", {31'd0, uart_tx[0]}, 32'd0);
        resetn = 1'b0;
        #1;
        chk("arst_uart_tx", {30'd0, uart_tx}, 32'd3);
        chk("arst_passed", {31'd0, tests_passed[0]}, 32'd0);
        chk("arst_valids", {30'd0, bvalid[0], rvalid[0]}, 32'd0);
        chk("arst_readies", {29'd0, awready[0], wready[0], arready[0]}, 32'd7);
        chk("arst_rdata", rdata[0], 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        axi_read(0, 32'h0000_0004, rd);
        chk("post_rst_status0", rd, 32'h0000_0002);
        axi_read(1, 32'h0000_0004, rd);
        chk("post_rst_status1", rd, 32'h0000_0002);
        repeat (20) @(negedge clk);
        chk("post_rst_line_idle", {30'd0, uart_tx}, 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
